clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
Time-setting controller for the board's hh:mm:ss timekeeper. It debounces the 5 push-keys and runs a RUN/SET_HOUR/SET_MIN/COMMIT state machine. It gates the timekeeper's count enable and issues a one-cycle load of the edited time. It also drives a digit-blink mask to the 7-seg display driver.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a synchronized key must stay stable before its debounced level changes (10 ms at 100 MHz)
BLINK_HALF, 25000000, cycles per half-period of the edit-field blink
IDLE_TIMEOUT, 1000000000, cycles with no accepted press in a SET state before abandoning the edit (10 s)
REPEAT_DELAY, 50000000, hold time before the first auto-repeat (AUTO_REPEAT_EN only)
REPEAT_RATE, 10000000, auto-repeat interval (AUTO_REPEAT_EN only)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
key  in  5  raw asynchronous keys, active-high: [0] MODE, [1] UP, [2] DOWN, [3] CONFIRM, [4] CANCEL
cur_hour  in  5  live hour from timekeeper, 0..23
cur_min  in  6  live minute from timekeeper, 0..59
run_en  out  1  timekeeper count enable
load  out  1  one-cycle pulse; timekeeper takes load_hour/load_min and clears seconds
load_hour  out  5  hour to load / edit value
load_min  out  6  minute to load / edit value
blink_mask  out  4  per-digit blank request [3:2]=hour digits, [1:0]=minute digits; 1 = blank
editing  out  1  high in SET_HOUR or SET_MIN

Behaviour:
- Reset: state RUN, run_en=1, load=0, load_hour=0, load_min=0, blink_mask=0, editing=0. All debouncers clear to released, and all timers clear.
- Key path: each key goes through a 2-FF synchronizer and then a debounce counter. The debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any return to the old value restarts the count.
- Press pulse: one cycle on the debounced 0->1 edge. Only one pulse is accepted per cycle, priority CANCEL > CONFIRM > MODE > UP > DOWN. Lower-priority pulses in that cycle are dropped.
- RUN:
  - MODE moves to SET_HOUR and captures cur_hour/cur_min into load_hour/load_min in the same edge.
  - run_en stays 1 in RUN; all other keys are ignored.
- SET_HOUR:
  - run_en=0 while editing.
  - UP: hour+1 with 23->0 wrap. DOWN: hour-1 with 0->23 wrap.
  - MODE moves to SET_MIN.
- SET_MIN:
  - UP: min+1 with 59->0 wrap. DOWN: min-1 with 0->59 wrap.
  - MODE moves back to SET_HOUR.
- From either SET state:
  - CONFIRM moves to COMMIT.
  - CANCEL, or the idle timer reaching IDLE_TIMEOUT, moves to RUN with no load and run_en back to 1 on the next cycle.
  - The idle timer clears on every accepted press and on SET entry.
- COMMIT: lasts exactly one cycle with load=1 and run_en=0. The next state is RUN with run_en=1. Seconds restart from 0 on the timekeeper side.
- Blink:
  - A free-running toggle with period 2*BLINK_HALF, restarted at 0 (visible phase) on SET entry and on each accepted UP/DOWN.
  - blink_mask=4'b1100 in SET_HOUR and 4'b0011 in SET_MIN while the toggle is in its blank phase; 0 otherwise.
- Edit values never leave their legal ranges. Out-of-range cur_hour/cur_min at capture are clamped to 23/59.
- Reset mid-edit: edit is discarded, RUN, run_en=1, no load pulse.
- All outputs are registered; press-to-effect latency is one cycle after the debounced edge.

Optional Feature:
AUTO_REPEAT_EN
- Defined: while UP or DOWN stays debounced-high in a SET state, an extra step pulse is generated REPEAT_DELAY cycles after the press, then every REPEAT_RATE cycles. Generated steps obey the same priority rules, wrap rules, idle-timer clear and blink restart. Releasing the key or changing state stops repeat.
- Undefined: one step per press only; repeat counters are not built.

Decomposition:
- Package clock_pkg: state enum (RUN, SET_HOUR, SET_MIN, COMMIT), key index constants (K_MODE..K_CANCEL), limits HOUR_MAX=23 and MIN_MAX=59.
- Sub-module key_debounce: a single key with synchronizer, debounce counter, and press-pulse output. It is instantiated 5 times, parameterized by DEBOUNCE_CYCLES.

Test Plan:
(Small parameters throughout: DEBOUNCE_CYCLES=4, BLINK_HALF=8, IDLE_TIMEOUT=200, REPEAT_DELAY=20, REPEAT_RATE=5.)
- Bounce rejection: MODE toggled 1/0 every 2 cycles for 20 cycles, then held 1 -> exactly one transition to SET_HOUR, 5 cycles after the stable hold begins (+sync), with editing=1 and run_en=0.
- Capture and wrap: cur_hour=23, cur_min=59; press MODE, UP -> load_hour=0; press MODE, UP -> load_min=0; press DOWN twice -> load_min=58.
- Commit: from SET_MIN with 07:30, press CONFIRM -> exactly one cycle load=1 with load_hour=7, load_min=30, then run_en=1 and editing=0.
- Cancel/timeout: enter SET, press UP, press CANCEL -> no load, RUN. Enter SET again with no press -> RUN after 200 cycles, no load.
- Priority: CONFIRM and CANCEL debounced in the same cycle in SET_HOUR -> RUN, no load pulse. UP and DOWN together -> +1 only.
- Blink/repeat: in SET_HOUR blink_mask alternates 1100/0000 every 8 cycles. With AUTO_REPEAT_EN, hold UP 40 cycles from hour=0 -> hour=5 (1 press + 4 repeats at 20, 25, 30, 35 cycles).

Source files
------------

// File: rtl/clock_set_ctrl_pkg.sv
// Shared types, key indices and time limits for the
// time-setting controller and its key debouncers.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN,
      SET_HOUR,
      SET_MIN,
      COMMIT
   } state_t;

   localparam int K_MODE    = 0;
   localparam int K_UP      = 1;
   localparam int K_DOWN    = 2;
   localparam int K_CONFIRM = 3;
   localparam int K_CANCEL  = 4;
   localparam int NKEYS     = 5;

   localparam logic [4:0] HOUR_MAX = 5'd23;
   localparam logic [5:0] MIN_MAX  = 6'd59;

   localparam logic [3:0] MASK_HOUR = 4'b1100;
   localparam logic [3:0] MASK_MIN  = 4'b0011;

   function automatic logic [4:0] hour_clamp(
      input logic [4:0] h
   );
      return (h > HOUR_MAX) ? HOUR_MAX : h;
   endfunction

   function automatic logic [5:0] min_clamp(
      input logic [5:0] m
   );
      return (m > MIN_MAX) ? MIN_MAX : m;
   endfunction

   // Wrapping +1/-1 of an hour value
   function automatic logic [4:0] hour_step(
      input logic [4:0] h,
      input logic       up
   );
      if (up)
         return (h >= HOUR_MAX) ? 5'd0 : h + 5'd1;
      return (h == 5'd0) ? HOUR_MAX : h - 5'd1;
   endfunction

   // Wrapping +1/-1 of a minute value
   function automatic logic [5:0] min_step(
      input logic [5:0] m,
      input logic       up
   );
      if (up)
         return (m >= MIN_MAX) ? 6'd0 : m + 6'd1;
      return (m == 6'd0) ? MIN_MAX : m - 6'd1;
   endfunction

endpackage

// File: rtl/clock_set_ctrl_key_debounce.sv
// One push-key: 2-FF synchronizer, stability counter, press pulse.
// Ports: clk, rst (sync, active-high), i_key raw key,
//   o_level debounced level, o_press one-cycle 0->1 pulse.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_key,
   output logic o_level,
   output logic o_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_press;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_key};
         r_press <= 1'b0;
         // Count consecutive disagreeing cycles; any
         // agreement restarts the count.
         if (r_sync[1] != r_level) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_level <= r_sync[1];
               r_press <= r_sync[1];
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: key debounce, RUN/SET/COMMIT FSM,
// timekeeper enable/load and display blink mask.
// Ports: clk, rst (sync, active-high), key[4:0] raw keys,
//   cur_hour/cur_min live time; run_en, load, load_hour,
//   load_min, blink_mask, editing (all registered).
// Option: define AUTO_REPEAT_EN for UP/DOWN auto-repeat.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BLINK_HALF      = 25000000,
   parameter int IDLE_TIMEOUT    = 1000000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_RATE     = 10000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   output logic       run_en,
   output logic       load,
   output logic [4:0] load_hour,
   output logic [5:0] load_min,
   output logic [3:0] blink_mask,
   output logic       editing
);

   logic [NKEYS-1:0] w_press;
   logic [NKEYS-1:0] w_level;

   for (genvar g = 0; g < NKEYS; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .rst    (rst),
         .i_key  (key[g]),
         .o_level(w_level[g]),
         .o_press(w_press[g])
      );
   end

   state_t      r_state;
   logic        r_run_en;
   logic        r_load;
   logic [4:0]  r_hour;
   logic [5:0]  r_min;
   logic [3:0]  r_mask;
   logic        r_editing;
   logic [31:0] r_idle;
   logic [31:0] r_bcnt;
   logic        r_ph;

   logic w_in_set;
   logic w_rep_up;
   logic w_rep_dn;
   logic w_up_ev;
   logic w_dn_ev;
   logic w_hi;
   logic w_acc_cancel;
   logic w_acc_confirm;
   logic w_acc_mode;
   logic w_acc_up;
   logic w_acc_dn;
   logic w_acc_any;
   logic w_timeout;
   logic w_blink_rst;
   logic w_bwrap;
   logic w_ph_nxt;

   assign w_in_set = (r_state == SET_HOUR) ||
                     (r_state == SET_MIN);

   // One accepted event per cycle:
   // CANCEL > CONFIRM > MODE > UP > DOWN
   assign w_up_ev = w_press[K_UP] | w_rep_up;
   assign w_dn_ev = w_press[K_DOWN] | w_rep_dn;
   assign w_hi    = w_press[K_CANCEL] |
                    w_press[K_CONFIRM] |
                    w_press[K_MODE];

   assign w_acc_cancel  = w_press[K_CANCEL];
   assign w_acc_confirm = w_press[K_CONFIRM] &
                          ~w_press[K_CANCEL];
   assign w_acc_mode    = w_press[K_MODE] &
                          ~w_press[K_CANCEL] &
                          ~w_press[K_CONFIRM];
   assign w_acc_up      = w_up_ev & ~w_hi;
   assign w_acc_dn      = w_dn_ev & ~w_up_ev & ~w_hi;
   assign w_acc_any     = w_acc_cancel | w_acc_confirm |
                          w_acc_mode | w_acc_up | w_acc_dn;

   // An accepted press in the same cycle wins over timeout
   assign w_timeout = w_in_set & ~w_acc_any &
                      (r_idle == 32'(IDLE_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || !w_in_set || w_acc_any)
         r_idle <= '0;
      else
         r_idle <= r_idle + 32'd1;
   end

   // Blink phase: 0 = visible, 1 = blank
   assign w_blink_rst = ((r_state == RUN) & w_acc_mode) |
                        (w_in_set & (w_acc_up | w_acc_dn));
   assign w_bwrap  = (r_bcnt == 32'(BLINK_HALF - 1));
   assign w_ph_nxt = w_blink_rst ? 1'b0 :
                     (w_bwrap ? ~r_ph : r_ph);

   always_ff @(posedge clk) begin
      if (rst || w_blink_rst || w_bwrap)
         r_bcnt <= '0;
      else
         r_bcnt <= r_bcnt + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_ph <= 1'b0;
      else
         r_ph <= w_ph_nxt;
   end

`ifdef AUTO_REPEAT_EN
   logic        r_rep_arm;
   logic        r_rep_dir;
   logic        r_rep_first;
   logic [31:0] r_rep_cnt;
   logic        w_rep_lvl;
   logic [31:0] w_rep_lim;
   logic        w_rep_fire;

   assign w_rep_lvl = r_rep_dir ? w_level[K_UP] :
                                  w_level[K_DOWN];
   assign w_rep_lim = r_rep_first ?
                      32'(REPEAT_DELAY - 1) :
                      32'(REPEAT_RATE - 1);
   assign w_rep_fire = r_rep_arm & w_in_set & w_rep_lvl &
                       (r_rep_cnt == w_rep_lim);
   assign w_rep_up = w_rep_fire & r_rep_dir;
   assign w_rep_dn = w_rep_fire & ~r_rep_dir;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rep_arm   <= 1'b0;
         r_rep_dir   <= 1'b0;
         r_rep_first <= 1'b1;
         r_rep_cnt   <= '0;
      end else if (!w_in_set || w_acc_cancel ||
                   w_acc_confirm || w_acc_mode ||
                   w_timeout) begin
         r_rep_arm <= 1'b0;
         r_rep_cnt <= '0;
      end else if (w_acc_up || w_acc_dn) begin
         r_rep_cnt <= '0;
         if (w_rep_fire) begin
            r_rep_first <= 1'b0;
         end else begin
            r_rep_arm   <= 1'b1;
            r_rep_first <= 1'b1;
            r_rep_dir   <= w_acc_up;
         end
      end else if (r_rep_arm && !w_rep_lvl) begin
         r_rep_arm <= 1'b0;
      end else if (r_rep_arm) begin
         r_rep_cnt <= r_rep_cnt + 32'd1;
      end
   end
`else
   localparam int unused_rep = REPEAT_DELAY + REPEAT_RATE;
   logic w_unused_lvl;
   assign w_unused_lvl = ^w_level;
   assign w_rep_up = 1'b0;
   assign w_rep_dn = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= RUN;
         r_run_en  <= 1'b1;
         r_load    <= 1'b0;
         r_hour    <= '0;
         r_min     <= '0;
         r_mask    <= '0;
         r_editing <= 1'b0;
      end else begin
         r_load <= 1'b0;
         case (r_state)
            RUN: begin
               r_run_en  <= 1'b1;
               r_editing <= 1'b0;
               r_mask    <= '0;
               if (w_acc_mode) begin
                  r_state   <= SET_HOUR;
                  r_hour    <= hour_clamp(cur_hour);
                  r_min     <= min_clamp(cur_min);
                  r_run_en  <= 1'b0;
                  r_editing <= 1'b1;
               end
            end
            SET_HOUR: begin
               r_mask <= w_ph_nxt ? MASK_HOUR : 4'b0;
               if (w_acc_cancel || w_timeout) begin
                  r_state   <= RUN;
                  r_run_en  <= 1'b1;
                  r_editing <= 1'b0;
                  r_mask    <= '0;
               end else if (w_acc_confirm) begin
                  r_state   <= COMMIT;
                  r_load    <= 1'b1;
                  r_editing <= 1'b0;
                  r_mask    <= '0;
               end else if (w_acc_mode) begin
                  r_state <= SET_MIN;
                  r_mask  <= w_ph_nxt ? MASK_MIN : 4'b0;
               end else if (w_acc_up || w_acc_dn) begin
                  r_hour <= hour_step(r_hour, w_acc_up);
               end
            end
            SET_MIN: begin
               r_mask <= w_ph_nxt ? MASK_MIN : 4'b0;
               if (w_acc_cancel || w_timeout) begin
                  r_state   <= RUN;
                  r_run_en  <= 1'b1;
                  r_editing <= 1'b0;
                  r_mask    <= '0;
               end else if (w_acc_confirm) begin
                  r_state   <= COMMIT;
                  r_load    <= 1'b1;
                  r_editing <= 1'b0;
                  r_mask    <= '0;
               end else if (w_acc_mode) begin
                  r_state <= SET_HOUR;
                  r_mask  <= w_ph_nxt ? MASK_HOUR : 4'b0;
               end else if (w_acc_up || w_acc_dn) begin
                  r_min <= min_step(r_min, w_acc_up);
               end
            end
            COMMIT: begin
               r_state   <= RUN;
               r_run_en  <= 1'b1;
               r_editing <= 1'b0;
               r_mask    <= '0;
            end
            default: begin
               r_state  <= RUN;
               r_run_en <= 1'b1;
            end
         endcase
      end
   end

   assign run_en     = r_run_en;
   assign load       = r_load;
   assign load_hour  = r_hour;
   assign load_min   = r_min;
   assign blink_mask = r_mask;
   assign editing    = r_editing;

endmodule
